sound_driver: RTL and testbench

//  Speaker driver for the Simon game. Consumes the controller's lamp code/enable and LOSE/HS flags.

---
 rtl/simon_pkg.sv | 33 +++
 rtl/tone_osc.sv | 45 ++++
 rtl/sound_driver.sv | 141 ++++++++++++++
 tb/tb_sound_driver.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Purpose : shared tone table, FSM state encoding and cycle-count helpers for the Simon sound path.
// Latency : n/a (constants and elaboration-time functions only).
// Backpressure: n/a.
package simon_pkg;

  // Tone frequencies in Hz
  localparam int unsigned TONE_LAMP [0:3] = '{415, 310, 252, 209};
  localparam int unsigned TONE_BUZZ       = 42;
  localparam int unsigned TONE_HS   [0:2] = '{523, 659, 784};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAMP_T  = 3'd1,
    LOSE_BZ = 3'd2,
    HS_N0   = 3'd3,
    HS_N1   = 3'd4,
    HS_N2   = 3'd5
  } snd_state_t;

  // Number of clock cycles in a duration given in milliseconds.
  // 64-bit so that e.g. 1500 ms at 50 MHz does not overflow.
  function automatic longint unsigned MS_CYCLES(input longint unsigned freq_in,
                                                input longint unsigned ms);
    return (ms * freq_in) / 64'd1000;
  endfunction

  // Half-period of a square wave of frequency f, truncated.
  function automatic int unsigned HALF_CYCLES(input int unsigned freq_in,
                                              input int unsigned f);
    return freq_in / (2 * f);
  endfunction

endpackage

// File: rtl/tone_osc.sv
// Purpose : square-wave generator: half-period counter plus toggle flop.
// Latency : first rising edge HALF cycles after RESTART; period 2*HALF cycles.
// Backpressure: none; free-running.
// Ports   : CLK, RST (async active-high), RESTART (clear count and output),
//           HALF (half-period in cycles, >= 1), OUT (square wave).
module tone_osc #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         RESTART,
  input  logic [W-1:0] HALF,
  output logic         OUT
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         out_q, out_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    out_d = out_q;
    if (RESTART) begin
      cnt_d = '0;
      out_d = 1'b0;
    end else if (cnt_q >= HALF - 1'b1) begin
      // >= rather than == so a count left over from a longer half-period
      // can never run away through a full wrap.
      cnt_d = '0;
      out_d = ~out_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign OUT = out_q;

endmodule

// File: rtl/sound_driver.sv
// Purpose : Simon speaker driver: lamp tones, loss buzz, 3-note high-score jingle.
// Latency : state changes on the edge that samples the trigger; first SPK rise HALF cycles later.
// Backpressure: none; LOSE/HS rises during LOSE_BZ are dropped.
// Ports   : CLK, RST (async active-high), LAMP[1:0], LAMP_ENA, LOSE, HS, MUTE in;
//           SPK (square wave), BUSY (not IDLE) out.
module sound_driver
  import simon_pkg::*;
#(
  parameter int unsigned FREQ_IN = 50_000_000,
  parameter int unsigned LOSE_MS = 1500,
  parameter int unsigned NOTE_MS = 150
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] LAMP,
  input  logic       LAMP_ENA,
  input  logic       LOSE,
  input  logic       HS,
  input  logic       MUTE,
  output logic       SPK,
  output logic       BUSY
);

  // The buzz is the lowest tone, so its half-period sizes the oscillator counter.
  localparam int unsigned HALF_BUZZ = HALF_CYCLES(FREQ_IN, TONE_BUZZ);
  localparam int          HW        = $clog2(HALF_BUZZ + 1);

  localparam logic [HW-1:0] HALF_LAMP [0:3] = '{
    HW'(HALF_CYCLES(FREQ_IN, TONE_LAMP[0])), HW'(HALF_CYCLES(FREQ_IN, TONE_LAMP[1])),
    HW'(HALF_CYCLES(FREQ_IN, TONE_LAMP[2])), HW'(HALF_CYCLES(FREQ_IN, TONE_LAMP[3]))};
  localparam logic [HW-1:0] HALF_HS [0:2] = '{
    HW'(HALF_CYCLES(FREQ_IN, TONE_HS[0])), HW'(HALF_CYCLES(FREQ_IN, TONE_HS[1])),
    HW'(HALF_CYCLES(FREQ_IN, TONE_HS[2]))};
  localparam logic [HW-1:0] HALF_BZ = HW'(HALF_BUZZ);

  localparam longint unsigned LOSE_CYC = MS_CYCLES(FREQ_IN, LOSE_MS);
  localparam longint unsigned NOTE_CYC = MS_CYCLES(FREQ_IN, NOTE_MS);
  localparam longint unsigned DUR_MAX  = (LOSE_CYC > NOTE_CYC) ? LOSE_CYC : NOTE_CYC;
  localparam int              TW       = $clog2(DUR_MAX + 1);
  localparam logic [TW-1:0]   LOSE_LAST = TW'(LOSE_CYC - 1);
  localparam logic [TW-1:0]   NOTE_LAST = TW'(NOTE_CYC - 1);

  snd_state_t    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          lose_q, hs_q;
  logic [1:0]    lamp_q;
  logic          restart;
  logic [HW-1:0] half;
  logic          osc_out;

  logic lose_rise, hs_rise;
  assign lose_rise = LOSE & ~lose_q;
  assign hs_rise   = HS & ~hs_q;

  // State register, duration timer and input history
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      timer_q <= '0;
      lose_q  <= 1'b0;
      hs_q    <= 1'b0;
      lamp_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      lose_q  <= LOSE;
      hs_q    <= HS;
      lamp_q  <= LAMP;
    end
  end

  // Next state; 'restart' marks any (re)entry that must reset oscillator and timer,
  // including same-state re-entries (lamp change, HS re-trigger mid-jingle).
  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    case (state_q)
      IDLE: begin
        if (lose_rise)     state_d = LOSE_BZ;
        else if (hs_rise)  state_d = HS_N0;
        else if (LAMP_ENA) state_d = LAMP_T;
      end
      LAMP_T: begin
        if (lose_rise)            state_d = LOSE_BZ;
        else if (hs_rise)         state_d = HS_N0;
        else if (!LAMP_ENA)       state_d = IDLE;
        else if (LAMP != lamp_q)  restart = 1'b1;
      end
      LOSE_BZ: begin
        if (timer_q == LOSE_LAST) state_d = IDLE;
      end
      HS_N0, HS_N1, HS_N2: begin
        if (lose_rise) begin
          state_d = LOSE_BZ;
        end else if (hs_rise) begin
          state_d = HS_N0;
          restart = 1'b1;
        end else if (timer_q == NOTE_LAST) begin
          case (state_q)
            HS_N0:   state_d = HS_N1;
            HS_N1:   state_d = HS_N2;
            default: state_d = IDLE;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) restart = 1'b1;

    // Timer only runs in the timed states; held at zero elsewhere.
    timer_d = '0;
    if (!restart && (state_q == LOSE_BZ || state_q == HS_N0 ||
                     state_q == HS_N1   || state_q == HS_N2)) begin
      timer_d = timer_q + 1'b1;
    end
  end

  // Outputs: half-period selection and speaker gating
  always_comb begin
    half = HALF_LAMP[lamp_q];
    case (state_q)
      LOSE_BZ: half = HALF_BZ;
      HS_N0:   half = HALF_HS[0];
      HS_N1:   half = HALF_HS[1];
      HS_N2:   half = HALF_HS[2];
      default: half = HALF_LAMP[lamp_q];
    endcase
    // MUTE only gates the pin; the oscillator keeps its phase underneath.
    SPK  = osc_out & ~MUTE & (state_q != IDLE);
    BUSY = (state_q != IDLE);
  end

  tone_osc #(.W(HW)) u_osc (
    .CLK     (CLK),
    .RST     (RST),
    .RESTART (restart),
    .HALF    (half),
    .OUT     (osc_out)
  );

endmodule

// File: tb/tb_sound_driver.sv
module tb_sound_driver;

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] LAMP;
  logic       LAMP_ENA, LOSE, HS, MUTE;
  logic       SPK, BUSY;

  int n_cmp = 0;
  int n_bad = 0;

  sound_driver #(.FREQ_IN(100_000), .LOSE_MS(5), .NOTE_MS(3)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .LAMP     (LAMP),
    .LAMP_ENA (LAMP_ENA),
    .LOSE     (LOSE),
    .HS       (HS),
    .MUTE     (MUTE),
    .SPK      (SPK),
    .BUSY     (BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0]  lamp;
    logic        ena;
    logic        lose;
    logic        hs;
    logic        mute;
    logic [15:0] ncyc;
    logic        spk;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [1:0] l, input logic e, input logic lo, input logic h,
                     input logic m, input int n, input logic s, input logic b);
    vec_t v;
    v.lamp = l; v.ena = e; v.lose = lo; v.hs = h; v.mute = m;
    v.ncyc = 16'(n); v.spk = s; v.busy = b;
    vecs.push_back(v);
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  // Wait for an SPK rise, then count cycles to the next rise.
  task automatic measure_period(input string nm, input int exp);
    logic p;
    bit   found;
    int   n;
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      p = SPK; step(1);
      if (!p && SPK) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL %s: no first rise within 2000 cycles, expected period %0d", nm, exp);
    end else begin
      found = 0; n = 0;
      for (int i = 0; i < 2000 && !found; i++) begin
        p = SPK; step(1); n++;
        if (!p && SPK) found = 1;
      end
      if (!found || n != exp) begin
        n_bad++;
        $display("FAIL %s: period %0d cycles expected %0d", nm, n, exp);
      end
    end
  endtask

  initial begin
    // Columns: lamp ena lose hs mute | cycles | spk busy
    // Lamp 0 tone (HALF 120) with mute over a high phase
    add(0,0,0,0,0,   1, 0,0);
    add(0,1,0,0,0,   1, 0,1);
    add(0,1,0,0,0, 119, 0,1);
    add(0,1,0,0,0,   1, 1,1);
    add(0,1,0,0,0, 119, 1,1);
    add(0,1,0,0,0,   1, 0,1);
    add(0,1,0,0,1,  10, 0,1);
    add(0,1,0,0,1, 118, 0,1);
    add(0,1,0,0,0,   0, 1,1);
    add(0,0,0,0,0,   1, 0,0);
    // Lamp 3 (HALF 239), then switch to lamp 0 mid high phase
    add(3,1,0,0,0,   1, 0,1);
    add(3,1,0,0,0, 238, 0,1);
    add(3,1,0,0,0,   1, 1,1);
    add(0,1,0,0,0,   1, 0,1);
    add(0,1,0,0,0, 119, 0,1);
    add(0,1,0,0,0,   1, 1,1);
    // LOSE in LAMP_T: 500-cycle buzz, second LOSE and HS rise ignored, back to lamp
    add(0,1,1,0,0,   1, 0,1);
    add(0,1,0,0,0, 100, 0,1);
    add(0,1,1,1,0, 100, 0,1);
    add(0,1,1,1,0, 299, 0,1);
    add(0,1,1,1,0,   1, 0,0);
    add(0,1,1,1,0,   1, 0,1);
    add(0,0,0,0,0,   1, 0,0);
    // Jingle: HALF 95 / 75 / 63, 300 cycles per note
    add(0,0,0,1,0,   1, 0,1);
    add(0,0,0,1,0,  94, 0,1);
    add(0,0,0,1,0,   1, 1,1);
    add(0,0,0,1,0, 204, 1,1);
    add(0,0,0,1,0,   1, 0,1);
    add(0,0,0,1,0,  74, 0,1);
    add(0,0,0,1,0,   1, 1,1);
    add(0,0,0,1,0, 225, 0,1);
    add(0,0,0,1,0,  62, 0,1);
    add(0,0,0,1,0,   1, 1,1);
    add(0,0,0,1,0, 236, 0,1);
    add(0,0,0,1,0,   1, 0,0);
    add(0,0,0,0,0,   1, 0,0);
    // LOSE rise during HS_N1 preempts to a full 500-cycle buzz
    add(0,0,0,1,0,   1, 0,1);
    add(0,0,0,1,0, 300, 0,1);
    add(0,0,0,1,0,  50, 0,1);
    add(0,0,1,1,0,   1, 0,1);
    add(0,0,1,1,0, 499, 0,1);
    add(0,0,1,1,0,   1, 0,0);
    add(0,0,0,0,0,   1, 0,0);
    // Simultaneous LOSE+HS: buzz only, no jingle afterwards
    add(0,0,1,1,0,   1, 0,1);
    add(0,0,1,1,0,  99, 0,1);
    add(0,0,1,1,0, 400, 0,1);
    add(0,0,1,1,0,   1, 0,0);
    add(0,0,1,1,0,   1, 0,0);
    add(0,0,0,0,0,   1, 0,0);

    RST = 1'b1; LAMP = 2'd0; LAMP_ENA = 1'b0; LOSE = 1'b0; HS = 1'b0; MUTE = 1'b0;
    #1;
    check("reset_spk", SPK, 1'b0);
    check("reset_busy", BUSY, 1'b0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;

    foreach (vecs[i]) begin
      LAMP = vecs[i].lamp; LAMP_ENA = vecs[i].ena; LOSE = vecs[i].lose;
      HS = vecs[i].hs; MUTE = vecs[i].mute;
      step(int'(vecs[i].ncyc));
      check($sformatf("vec%0d_spk", i), SPK, vecs[i].spk);
      check($sformatf("vec%0d_busy", i), BUSY, vecs[i].busy);
    end

    // Tone periods: lamp0 2*120, then lamp3 2*239 after a lamp change
    LAMP = 2'd0; LAMP_ENA = 1'b1;
    measure_period("period_lamp0", 240);
    LAMP = 2'd3;
    measure_period("period_lamp3", 478);
    LAMP_ENA = 1'b0;
    step(1);
    check("period_done_busy", BUSY, 1'b0);

    // Asynchronous reset mid-cycle while a lamp tone is high
    LAMP = 2'd0; LAMP_ENA = 1'b1;
    step(121);
    check("pre_rst_spk", SPK, 1'b1);
    #2 RST = 1'b1;
    #1;
    check("async_rst_spk", SPK, 1'b0);
    check("async_rst_busy", BUSY, 1'b0);
    #2 RST = 1'b0;
    #1;
    check("post_rst_busy", BUSY, 1'b0);
    step(1);
    check("post_rst_relamp_busy", BUSY, 1'b1);
    check("post_rst_relamp_spk", SPK, 1'b0);
    LAMP_ENA = 1'b0;
    step(1);
    check("final_idle_busy", BUSY, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
